// File: rtl/bcd_code_converter.sv
// Digit-serial decimal code converter: BCD<->Excess-3, BCD->Aiken 2421 and BCD->binary,
// one digit per clock (most significant digit first) behind valid/ready handshakes.
module bcd_code_converter #(
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [4*DIGITS-1:0]   i_in_data,
    input  logic [1:0]            i_in_mode,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [4*DIGITS-1:0]   o_out_data,
    output logic [DIGITS-1:0]     o_out_err
);

    localparam int W    = 4 * DIGITS;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] MODE_BCD2XS3  = 2'b00;
    localparam logic [1:0] MODE_XS32BCD  = 2'b01;
    localparam logic [1:0] MODE_BCD2AIK  = 2'b10;
    localparam logic [1:0] MODE_BCD2BIN  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic [W-1:0]       r_shift;
    logic [1:0]         r_mode;
    logic [IDXW-1:0]    r_idx;
    logic [W-1:0]       r_acc;
    logic [W-1:0]       r_outData;
    logic [DIGITS-1:0]  r_outErr;
    logic               r_outValid;

    logic [3:0]         w_digit;
    logic [3:0]         w_mapped;
    logic [3:0]         w_accDigit;
    logic               w_bad;
    logic [W-1:0]       w_accNext;
    logic [W-1:0]       w_outDataNext;
    logic [DIGITS-1:0]  w_errNext;
    logic               w_accept;
    logic               w_lastDigit;

    assign w_accept    = (r_state == IDLE) && i_in_valid;
    assign w_lastDigit = (r_idx == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (i_in_valid) begin
                    w_stateNext = CONV;
                end
            end
            CONV: begin
                if (w_lastDigit) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (i_out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // The captured word is shifted left each cycle, so the digit in flight is always the top nibble.
    always_comb begin
        w_digit    = r_shift[W-1 -: 4];
        w_mapped   = 4'd0;
        w_accDigit = 4'd0;
        w_bad      = 1'b0;
        case (r_mode)
            MODE_BCD2XS3: begin
                if (w_digit <= 4'd9) begin
                    w_mapped = w_digit + 4'd3;
                end else begin
                    w_bad = 1'b1;
                end
            end
            MODE_XS32BCD: begin
                if ((w_digit >= 4'd3) && (w_digit <= 4'd12)) begin
                    w_mapped = w_digit - 4'd3;
                end else begin
                    w_bad = 1'b1;
                end
            end
            MODE_BCD2AIK: begin
                if (w_digit <= 4'd4) begin
                    w_mapped = w_digit;
                end else if (w_digit <= 4'd9) begin
                    w_mapped = w_digit + 4'd6;
                end else begin
                    w_bad = 1'b1;
                end
            end
            MODE_BCD2BIN: begin
                if (w_digit <= 4'd9) begin
                    w_accDigit = w_digit;
                end else begin
                    w_bad = 1'b1;
                end
            end
            default: w_bad = 1'b0;
        endcase
    end

    // acc*10 as two shifts; 10^DIGITS-1 always fits in W bits, so no overflow handling is needed.
    assign w_accNext = (r_acc << 3) + (r_acc << 1) + W'(w_accDigit);

    always_comb begin
        w_outDataNext = r_outData;
        w_errNext     = r_outErr;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_errNext[i] = w_bad;
                if (r_mode != MODE_BCD2BIN) begin
                    w_outDataNext[4*i +: 4] = w_mapped;
                end
            end
        end
        if ((r_mode == MODE_BCD2BIN) && w_lastDigit) begin
            w_outDataNext = w_accNext;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shift    <= '0;
            r_mode     <= 2'b00;
            r_idx      <= '0;
            r_acc      <= '0;
            r_outData  <= '0;
            r_outErr   <= '0;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= (w_stateNext == DONE);
            if (w_accept) begin
                r_shift  <= i_in_data;
                r_mode   <= i_in_mode;
                r_idx    <= IDXW'(DIGITS - 1);
                r_acc    <= '0;
                r_outErr <= '0;
            end else if (r_state == CONV) begin
                r_shift   <= r_shift << 4;
                r_idx     <= r_idx - 1'b1;
                r_acc     <= w_accNext;
                r_outData <= w_outDataNext;
                r_outErr  <= w_errNext;
            end
        end
    end

    assign o_in_ready  = (r_state == IDLE) && i_rst_n;
    assign o_out_valid = r_outValid;
    assign o_out_data  = r_outData;
    assign o_out_err   = r_outErr;

endmodule

// File: doc/bcd_code_converter.md
# bcd_code_converter

Parametrised, digit-serial decimal code converter. It accepts a packed word of DIGITS 4-bit decimal digits over a valid/ready handshake and converts it one digit per clock in one of four modes: BCD→Excess-3, Excess-3→BCD, BCD→Aiken 2421 and BCD→binary. It flags invalid input digits per position and holds the result under output backpressure. It sits between decimal front-end logic (keypad/display paths) and arithmetic or display datapaths in the combinational/encoders family.

## Interface
- DIGITS, 4: number of decimal digits per word; legal values are 1 to 8.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset; one clock, no asynchronous path.
- in_valid  input  1  input word present.
- in_ready  output  1  converter can accept a word; equals (state==IDLE) && rst_n.
- in_data  input  4*DIGITS  packed input digits; digit i is in_data[4i+3:4i]; digit DIGITS-1 is the most significant.
- in_mode  input  2  00 BCD→XS3, 01 XS3→BCD, 10 BCD→2421, 11 BCD→binary.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  4*DIGITS  converted digits, packed the same way as in_data; in binary mode, an unsigned zero-extended integer.
- out_err  output  DIGITS  bit i set means input digit i was invalid for the selected mode.

## Operation
- FSM has three states: IDLE, CONV, DONE.
- IDLE: in_ready=1.
  - On in_valid && in_ready, capture in_data and in_mode, clear the accumulator and error register, and set the digit index to DIGITS-1. Go to CONV.
- CONV: one digit per clock, MSD first, index DIGITS-1 down to 0.
  - After index 0 is processed, go to DONE.
  - in_ready=0 and in_valid is ignored.
- DONE: out_valid=1. out_data and out_err are registered and stable until the handshake.
  - On out_ready, go to IDLE.
- Per-digit mapping for input digit d:
  - Mode 00: d≤9 gives d+3; otherwise 0 and the error bit is set.
  - Mode 01: 3≤d≤12 gives d−3; otherwise 0 and the error bit is set.
  - Mode 10: d≤4 gives d; 5≤d≤9 gives d+6; otherwise 0 and the error bit is set.
  - Mode 11: acc = acc*10 + d'. d'=d when d≤9; otherwise d'=0 and the error bit is set.
    - Accumulator width is 4*DIGITS bits; 10^DIGITS−1 always fits, so there is no overflow.
    - out_data = acc when the state enters DONE.
- Digit modes (00, 01, 10) write output digit i in the cycle that processes index i.
- in_mode is sampled only at acceptance. Changes while busy have no effect.
- Synchronous reset in any state:
  - Next state IDLE.
  - out_valid=0, out_data=0, out_err=0.
  - Any in-flight word is discarded.
  - in_ready=0 while rst_n=0 and 1 in the first cycle after release.
- After the DONE handshake, out_data and out_err retain their last values and out_valid=0.

## Timing
- Accept at edge E0 (state→CONV). Digits are processed at edges E1..E_DIGITS. State=DONE after E_DIGITS.
- out_valid is first high in the cycle following E_DIGITS, giving DIGITS+1 cycles from acceptance to out_valid.
- With out_ready held at 1:
  - DONE lasts 1 cycle, then IDLE lasts 1 cycle.
  - Minimum spacing between acceptances is DIGITS+2 cycles.
- in_ready and out_valid are never high in the same cycle.
- Backpressure: DONE is held indefinitely while out_ready=0, with no change in out_data or out_err.
- out_ready high outside DONE has no effect.
- All outputs are registered except in_ready, which decodes from the state register.

## Test plan
- Reset, then DIGITS=4, mode 00, in_data=16'h1234 → out_data=16'h4567, out_err=4'b0000, out_valid first high 5 cycles after the accept edge.
- Mode 01, in_data=16'h3C4A → 16'h0917, err 0. Then in_data=16'h3A21 → 16'h0700, out_err=4'b0011.
- Mode 11, in_data=16'h9999 → 16'h270F. Then 16'h12F4 → 16'h04B4 (decimal 1204), out_err=4'b0010.
- Mode 10, in_data=16'h5907 → 16'hBF0D. Then 16'h4BCD → 16'h4000, out_err=4'b0111.
- Backpressure: hold out_ready=0 for 3 cycles in DONE, toggling in_valid and in_data. Expect out_valid=1 and out_data/out_err unchanged, in_ready=0, and no new word accepted. Raise out_ready: next cycle out_valid=0 and in_ready=1.
- Pull rst_n low for one cycle mid-CONV (after E2). Next cycle all outputs are 0 and the state is IDLE. A following 16'h0000 in mode 00 converts to 16'h3333 with no trace of the aborted word.
